text_message_sequencer: RTL and testbench
=========================================

// Module: text_message_sequencer
// PURPOSE
//  Schedules on-screen text messages from NUM_REQ requesters onto one text display, one message at a time.
//  Drives the shared text display timer: timer_en high while a message is shown; the timer's done pulse ends it.
//  Round-robin arbitration; a forced blank gap between messages lets the timer clear its count.
// PARAMETERS
//  NUM_REQ      4    number of requesters (>=2)
//  MSG_W        4    message-ID width
//  BLANK_CYCLES 2    display-off cycles between messages (>=1)
//  WATCHDOG     0    max SHOW cycles before forced end; 0 = disabled
// PORTS
//  clk        in   1              system clock, all state on rising edge
//  reset_n    in   1              asynchronous, active-low reset
//  req        in   NUM_REQ        per-requester display request, held until granted
//  msg_id     in   NUM_REQ*MSG_W  requester i message ID in bits [i*MSG_W +: MSG_W]
//  grant      out  NUM_REQ        one-hot, 1-cycle pulse: request i accepted
//  abort      in   1              cancel the message currently shown
//  timer_en   out  1              enable to the text display timer
//  timer_done in   1              end-of-time pulse from the timer
//  disp_valid out  1              message on screen
//  disp_msg   out  MSG_W          ID of message on screen
//  busy       out  1              state != IDLE
//  wd_err     out  1              1-cycle pulse: watchdog forced end
// BEHAVIOUR
//  Reset (reset_n low, any state): state=IDLE, grant=0, timer_en=0, disp_valid=0, disp_msg=0, busy=0,
//   wd_err=0, rr_ptr=NUM_REQ-1 (requester 0 wins first), blank and watchdog counters=0.
//  All outputs are registered. States: IDLE, SHOW, BLANK.
//  Arbitration: search indices rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ); first with req=1 wins.
//   On win: rr_ptr=winner, disp_msg=msg_id[winner], grant[winner]=1 for exactly one cycle.
//  IDLE: req==0 -> stay. req!=0 at edge -> SHOW; in the next cycle grant, disp_valid, timer_en are 1 together.
//  SHOW: timer_en=1, disp_valid=1, disp_msg stable. Leave to BLANK at the edge that samples:
//   timer_done=1, or abort=1, or (WATCHDOG>0 and SHOW cycle count reaches WATCHDOG; wd_err pulses).
//   Same-cycle priority: timer_done = abort > watchdog; wd_err only when the watchdog alone ends SHOW.
//   The grant cycle is SHOW cycle 1.
//  BLANK: timer_en=0, disp_valid=0, disp_msg holds its last value; lasts exactly BLANK_CYCLES cycles.
//   On the last BLANK cycle: req!=0 -> arbitrate and go straight to SHOW; else -> IDLE.
//  Requesters hold req and msg_id stable until they see grant, then drop req in the grant cycle
//   (sampled req in the grant cycle is ignored: state is SHOW).
//  timer_done and abort are ignored outside SHOW. A request that drops before it is granted is lost, no error.
//  Reset mid-SHOW: timer_en drops asynchronously, so the timer count clears; the message is not resumed.
//  Minimum back-to-back period = (SHOW cycles) + BLANK_CYCLES; timer_en is never high two periods without a low gap.
// TESTING
//  1. Single req[0], msg_id0=5; timer_done 6 cycles after grant -> grant=0001 1 cycle, disp_msg=5, disp_valid 7 cycles, 2 BLANK, IDLE.
//  2. req=1111 held, IDs 1..4, each dropped on grant -> grants in order 0,1,2,3, each message separated by exactly 2 blank cycles.
//  3. abort asserted on SHOW cycle 3 -> BLANK next cycle, timer_en=0; timer_done pulse during BLANK is ignored.
//  4. WATCHDOG=10, timer_done never pulses -> wd_err pulses once, SHOW lasts exactly 10 cycles, then BLANK.
//  5. reset_n low mid-SHOW for 1 cycle -> all outputs 0 immediately; after release req[2] granted before req[3].
//  6. timer_done and abort pulsed in IDLE with req=0 -> no state change, all outputs stay 0.

Source files
------------

// File: rtl/text_message_sequencer_if.sv
// -----------------------------------------------------------------------------
// text_message_sequencer_if
//   Bundles the requester handshake, the display-timer handshake and the
//   display/status outputs of text_message_sequencer.
//   master : requesters + timer side (drives req, msg_id, abort, timer_done)
//   slave  : the sequencer (drives grant, timer_en, disp_*, busy, wd_err)
// -----------------------------------------------------------------------------
interface text_message_sequencer_if #(
  parameter int NUM_REQ = 4,
  parameter int MSG_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*MSG_W-1:0] msg_id;
  logic [NUM_REQ-1:0]       grant;
  logic                     abort;
  logic                     timer_en;
  logic                     timer_done;
  logic                     disp_valid;
  logic [MSG_W-1:0]         disp_msg;
  logic                     busy;
  logic                     wd_err;

  modport master (
    output req, msg_id, abort, timer_done,
    input  grant, timer_en, disp_valid, disp_msg, busy, wd_err
  );

  modport slave (
    input  req, msg_id, abort, timer_done,
    output grant, timer_en, disp_valid, disp_msg, busy, wd_err
  );
endinterface

// File: rtl/text_message_sequencer.sv
// -----------------------------------------------------------------------------
// text_message_sequencer
//   Puts messages from NUM_REQ requesters onto one text display, one at a
//   time, with round-robin arbitration. While a message is shown the display
//   timer is enabled; its done pulse (or abort, or the optional watchdog) ends
//   the message, followed by BLANK_CYCLES display-off cycles so the timer can
//   clear before the next message.
// Ports
//   clk      : system clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of text_message_sequencer_if
//              (req/msg_id/abort/timer_done in; grant/timer_en/disp_valid/
//               disp_msg/busy/wd_err out, all outputs registered)
// -----------------------------------------------------------------------------
module text_message_sequencer #(
  parameter int NUM_REQ      = 4,
  parameter int MSG_W        = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int WATCHDOG     = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  text_message_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BL_W  = $clog2(BLANK_CYCLES + 1);
  localparam int WD_W  = (WATCHDOG > 0) ? $clog2(WATCHDOG + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BL_W-1:0]    blank_cnt_q, blank_cnt_d;
  logic [WD_W-1:0]    show_cnt_q, show_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               timer_en_q, timer_en_d;
  logic               disp_valid_q, disp_valid_d;
  logic [MSG_W-1:0]   disp_msg_q, disp_msg_d;
  logic               busy_q, busy_d;
  logic               wd_err_q, wd_err_d;

  // Per-requester view of the packed message-ID bus.
  logic [MSG_W-1:0] msg_arr [NUM_REQ];
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_msg
      assign msg_arr[gi] = bus.msg_id[gi*MSG_W +: MSG_W];
    end
  endgenerate

  // Round-robin search starting just after the last winner.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  always_comb begin
    logic [IDX_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    idx       = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  logic wd_fire, show_end, blank_last, take;
  assign wd_fire    = (WATCHDOG > 0) && (show_cnt_q == WD_W'(WATCHDOG));
  assign show_end   = bus.timer_done | bus.abort | wd_fire;
  assign blank_last = (blank_cnt_q == BL_W'(BLANK_CYCLES));

  // State register (plus all registered outputs).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      blank_cnt_q  <= '0;
      show_cnt_q   <= '0;
      grant_q      <= '0;
      timer_en_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_msg_q   <= '0;
      busy_q       <= 1'b0;
      wd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      blank_cnt_q  <= blank_cnt_d;
      show_cnt_q   <= show_cnt_d;
      grant_q      <= grant_d;
      timer_en_q   <= timer_en_d;
      disp_valid_q <= disp_valid_d;
      disp_msg_q   <= disp_msg_d;
      busy_q       <= busy_d;
      wd_err_q     <= wd_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    blank_cnt_d = blank_cnt_q;
    show_cnt_d  = show_cnt_q;
    take        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = SHOW;
          take    = 1'b1;
        end
      end
      SHOW: begin
        if (show_end) begin
          state_d     = BLANK;
          blank_cnt_d = BL_W'(1);
          show_cnt_d  = '0;
        end else if (WATCHDOG > 0) begin
          show_cnt_d = show_cnt_q + WD_W'(1);
        end
      end
      BLANK: begin
        if (blank_last) begin
          blank_cnt_d = '0;
          if (win_found) begin
            state_d = SHOW;
            take    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          blank_cnt_d = blank_cnt_q + BL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // The grant cycle counts as SHOW cycle 1.
    if (take) begin
      rr_ptr_d   = win_idx;
      show_cnt_d = WD_W'(1);
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    grant_d      = '0;
    disp_msg_d   = disp_msg_q;
    if (take) begin
      grant_d    = NUM_REQ'(1) << win_idx;
      disp_msg_d = msg_arr[win_idx];
    end
    timer_en_d   = (state_d == SHOW);
    disp_valid_d = (state_d == SHOW);
    busy_d       = (state_d != IDLE);
    // Only flag the watchdog when it alone is what ends the message.
    wd_err_d     = (state_q == SHOW) && wd_fire && !bus.timer_done && !bus.abort;
  end

  assign bus.grant      = grant_q;
  assign bus.timer_en   = timer_en_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_msg   = disp_msg_q;
  assign bus.busy       = busy_q;
  assign bus.wd_err     = wd_err_q;

endmodule

// File: tb/tb_text_message_sequencer.sv
// -----------------------------------------------------------------------------
// tb_text_message_sequencer
//   Directed bench for text_message_sequencer (NUM_REQ=4, MSG_W=4,
//   BLANK_CYCLES=2, WATCHDOG=10). Inputs change 1 ns after a rising edge and
//   outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_text_message_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_message_sequencer_if #(.NUM_REQ(4), .MSG_W(4)) bus_if ();

  text_message_sequencer #(
    .NUM_REQ(4), .MSG_W(4), .BLANK_CYCLES(2), .WATCHDOG(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus_if.req = '0; bus_if.msg_id = '0; bus_if.abort = 0; bus_if.timer_done = 0;
    reset_n = 0;
    tick; tick; tick;
    checks++; if (bus_if.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", bus_if.grant); end
    checks++; if (bus_if.timer_en !== 1'b0) begin errors++; $display("FAIL reset_timer_en got %b want 0", bus_if.timer_en); end
    checks++; if (bus_if.disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid got %b want 0", bus_if.disp_valid); end
    checks++; if (bus_if.disp_msg !== 4'd0) begin errors++; $display("FAIL reset_disp_msg got %0d want 0", bus_if.disp_msg); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
    checks++; if (bus_if.wd_err !== 1'b0) begin errors++; $display("FAIL reset_wd_err got %b want 0", bus_if.wd_err); end
    reset_n = 1;
    tick;
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_idle_pulses;
    logic [11:0] outs;
    for (int p = 0; p < 4; p++) begin
      bus_if.timer_done = (p == 0 || p == 2);
      bus_if.abort      = (p == 1 || p == 2);
      tick;
      outs = {bus_if.grant, bus_if.timer_en, bus_if.disp_valid, bus_if.disp_msg, bus_if.busy, bus_if.wd_err};
      checks++; if (outs !== 12'h000) begin errors++; $display("FAIL idle_pulse_%0d got %h want 000", p, outs); end
    end
    bus_if.timer_done = 0; bus_if.abort = 0;
    $display("idle: timer_done/abort pulses ignored");
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_g;
    int n = 0, show_len = 0, gap = 0;
    bit done = 0;
    bus_if.msg_id = {4'd4, 4'd3, 4'd2, 4'd1};
    bus_if.req    = 4'b1111;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      tick;
      bus_if.timer_done = 0;
      if (bus_if.grant !== 4'b0000) begin
        exp_g = 4'b0001 << n;
        checks++; if (bus_if.grant !== exp_g) begin errors++; $display("FAIL b2b_grant_%0d got %b want %b", n, bus_if.grant, exp_g); end
        checks++; if (bus_if.disp_msg !== 4'(n + 1)) begin errors++; $display("FAIL b2b_msg_%0d got %0d want %0d", n, bus_if.disp_msg, n + 1); end
        if (n > 0) begin
          checks++; if (gap !== 2) begin errors++; $display("FAIL b2b_gap_%0d got %0d want 2", n, gap); end
        end
        $display("b2b: grant=%b msg=%0d gap=%0d", bus_if.grant, bus_if.disp_msg, gap);
        bus_if.req = bus_if.req & ~bus_if.grant;
        n++; show_len = 0; gap = 0;
      end
      if (bus_if.disp_valid) begin
        show_len++;
        if (show_len == 3) bus_if.timer_done = 1;
      end else begin
        gap++;
      end
      if (n == 4 && !bus_if.busy) done = 1;
    end
    bus_if.req = '0; bus_if.timer_done = 0;
    checks++; if (!done) begin errors++; $display("FAIL b2b_timeout grants %0d want 4 then idle", n); end
  endtask

  task automatic test_single;
    int valid = 0, grants = 0;
    bus_if.msg_id = {4'd0, 4'd0, 4'd0, 4'd5};
    bus_if.req    = 4'b0001;
    tick;
    checks++; if (bus_if.grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", bus_if.grant); end
    checks++; if (bus_if.disp_msg !== 4'd5) begin errors++; $display("FAIL single_msg got %0d want 5", bus_if.disp_msg); end
    checks++; if (bus_if.timer_en !== 1'b1) begin errors++; $display("FAIL single_timer_en got %b want 1", bus_if.timer_en); end
    bus_if.req = '0;
    if (bus_if.disp_valid) valid++;
    if (bus_if.grant !== 4'b0000) grants++;
    for (int c = 2; c <= 7; c++) begin
      tick;
      if (bus_if.disp_valid) valid++;
      if (bus_if.grant !== 4'b0000) grants++;
      if (c == 7) bus_if.timer_done = 1;
    end
    tick;
    bus_if.timer_done = 0;
    checks++; if (bus_if.disp_valid !== 1'b0) begin errors++; $display("FAIL single_blank_valid got %b want 0", bus_if.disp_valid); end
    checks++; if (bus_if.timer_en !== 1'b0) begin errors++; $display("FAIL single_blank_timer_en got %b want 0", bus_if.timer_en); end
    checks++; if (bus_if.disp_msg !== 4'd5) begin errors++; $display("FAIL single_blank_msg got %0d want 5", bus_if.disp_msg); end
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL single_blank1_busy got %b want 1", bus_if.busy); end
    tick;
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL single_blank2_busy got %b want 1", bus_if.busy); end
    tick;
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", bus_if.busy); end
    checks++; if (valid !== 7) begin errors++; $display("FAIL single_valid_len got %0d want 7", valid); end
    checks++; if (grants !== 1) begin errors++; $display("FAIL single_grant_len got %0d want 1", grants); end
    $display("single: msg=5 shown %0d cycles, grant %0d cycle(s)", valid, grants);
  endtask

  task automatic test_abort;
    bus_if.msg_id = {4'd0, 4'd0, 4'd7, 4'd0};
    bus_if.req    = 4'b0010;
    tick;
    checks++; if (bus_if.grant !== 4'b0010) begin errors++; $display("FAIL abort_grant got %b want 0010", bus_if.grant); end
    bus_if.req = '0;
    tick; tick;
    checks++; if (bus_if.timer_en !== 1'b1) begin errors++; $display("FAIL abort_show3_timer_en got %b want 1", bus_if.timer_en); end
    bus_if.abort = 1;
    tick;
    bus_if.abort = 0;
    checks++; if (bus_if.timer_en !== 1'b0) begin errors++; $display("FAIL abort_timer_en got %b want 0", bus_if.timer_en); end
    checks++; if (bus_if.disp_valid !== 1'b0) begin errors++; $display("FAIL abort_disp_valid got %b want 0", bus_if.disp_valid); end
    checks++; if (bus_if.wd_err !== 1'b0) begin errors++; $display("FAIL abort_wd_err got %b want 0", bus_if.wd_err); end
    bus_if.timer_done = 1;
    tick;
    bus_if.timer_done = 0;
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL abort_blank2_busy got %b want 1", bus_if.busy); end
    tick;
    checks++; if (bus_if.busy !== 1'b0 || bus_if.timer_en !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b timer_en=%b want 0 0", bus_if.busy, bus_if.timer_en); end
    $display("abort: message 7 cut on SHOW cycle 3");
  endtask

  task automatic test_watchdog;
    int show, wd;
    // Watchdog alone ends the message.
    bus_if.msg_id = {4'd11, 4'd9, 4'd0, 4'd0};
    bus_if.req    = 4'b0100;
    tick;
    checks++; if (bus_if.grant !== 4'b0100) begin errors++; $display("FAIL wd_grant got %b want 0100", bus_if.grant); end
    bus_if.req = '0;
    show = 1; wd = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus_if.wd_err) wd++;
      if (!bus_if.disp_valid) break;
      show++;
    end
    checks++; if (show !== 10) begin errors++; $display("FAIL wd_show_len got %0d want 10", show); end
    checks++; if (bus_if.wd_err !== 1'b1) begin errors++; $display("FAIL wd_err_blank1 got %b want 1", bus_if.wd_err); end
    tick;
    if (bus_if.wd_err) wd++;
    checks++; if (wd !== 1) begin errors++; $display("FAIL wd_pulses got %0d want 1", wd); end
    tick;
    $display("watchdog: forced end after %0d cycles", show);
    // timer_done on the watchdog cycle takes priority: no wd_err.
    bus_if.req = 4'b1000;
    tick;
    checks++; if (bus_if.grant !== 4'b1000 || bus_if.disp_msg !== 4'd11) begin errors++; $display("FAIL wd2_grant got %b/%0d want 1000/11", bus_if.grant, bus_if.disp_msg); end
    bus_if.req = '0;
    show = 1; wd = 0;
    for (int i = 0; i < 20; i++) begin
      if (show == 10) bus_if.timer_done = 1;
      tick;
      bus_if.timer_done = 0;
      if (bus_if.wd_err) wd++;
      if (!bus_if.disp_valid) break;
      show++;
    end
    tick;
    if (bus_if.wd_err) wd++;
    checks++; if (show !== 10) begin errors++; $display("FAIL wd2_show_len got %0d want 10", show); end
    checks++; if (wd !== 0) begin errors++; $display("FAIL wd2_pulses got %0d want 0", wd); end
    tick;
    $display("watchdog: timer_done on cycle 10 suppresses wd_err");
  endtask

  task automatic test_reset_mid_show;
    logic [11:0] outs;
    bus_if.msg_id = {4'd12, 4'd10, 4'd0, 4'd0};
    bus_if.req    = 4'b0100;
    tick;
    checks++; if (bus_if.grant !== 4'b0100) begin errors++; $display("FAIL rst_pre_grant got %b want 0100", bus_if.grant); end
    bus_if.req = '0;
    tick;
    reset_n = 0;
    #1;
    outs = {bus_if.grant, bus_if.timer_en, bus_if.disp_valid, bus_if.disp_msg, bus_if.busy, bus_if.wd_err};
    checks++; if (outs !== 12'h000) begin errors++; $display("FAIL rst_async_outputs got %h want 000", outs); end
    @(posedge clk);
    #1;
    reset_n = 1;
    bus_if.req = 4'b1100;
    tick;
    checks++; if (bus_if.grant !== 4'b0100 || bus_if.disp_msg !== 4'd10) begin errors++; $display("FAIL rst_first_grant got %b/%0d want 0100/10", bus_if.grant, bus_if.disp_msg); end
    bus_if.req = 4'b1000;
    bus_if.timer_done = 1;
    tick;
    bus_if.timer_done = 0;
    tick; tick;
    checks++; if (bus_if.grant !== 4'b1000 || bus_if.disp_msg !== 4'd12) begin errors++; $display("FAIL rst_second_grant got %b/%0d want 1000/12", bus_if.grant, bus_if.disp_msg); end
    bus_if.req = '0;
    bus_if.timer_done = 1;
    tick;
    bus_if.timer_done = 0;
    tick; tick;
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rst_final_idle got %b want 0", bus_if.busy); end
    $display("reset mid-show: req2 then req3 granted after release");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_idle_pulses;
    test_back_to_back;
    test_single;
    test_abort;
    test_watchdog;
    test_reset_mid_show;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
